// File: rtl/divider_scheduler_if.sv
// Request/grant bus between the requesters and the shared divider scheduler.
interface divider_scheduler_if #(
    parameter int unsigned bitField = 4
);
    logic [1:0]          REQ;
    logic [bitField-1:0] N0;
    logic [bitField-1:0] N1;
    logic [bitField-1:0] CYC0;
    logic [bitField-1:0] CYC1;
    logic [1:0]          GNT;
    logic                BUSY;
    logic                OUT;
    logic [bitField-1:0] Count;
    logic [1:0]          DONE;

    // Requester side drives requests and job parameters.
    modport master (
        output REQ, N0, N1, CYC0, CYC1,
        input  GNT, BUSY, OUT, Count, DONE
    );

    // Scheduler side answers with grant, divider pulses and completion.
    modport slave (
        input  REQ, N0, N1, CYC0, CYC1,
        output GNT, BUSY, OUT, Count, DONE
    );
endinterface

// File: rtl/divider_scheduler.sv
// Round-robin scheduler sharing one modulo-N event counter between two
// requesters; emits one OUT pulse per divide period and a DONE pulse per job.
module divider_scheduler #(
    parameter int unsigned bitField = 4,
    parameter int unsigned NMIN     = 2
) (
    input logic                CLK,
    input logic                CLEAR,
    divider_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t              state;
    logic                win;
    logic                last;
    logic [bitField-1:0] ratio_r;
    logic [bitField-1:0] rem_r;

    logic                pick_c;
    logic [bitField-1:0] n_pick_c;
    logic [bitField-1:0] cyc_pick_c;
    logic [bitField-1:0] ratio_pick_c;
    logic [bitField-1:0] ratio_m1_c;
    logic [bitField-1:0] ratio_m2_c;
    logic                req_win_c;

    // Winner selection and clamped ratio for the next grant decision.
    always_comb begin
        pick_c = 1'b0;
        if (bus.REQ == 2'b10) begin
            pick_c = 1'b1;
        end else if (bus.REQ == 2'b11) begin
            pick_c = ~last;
        end
        n_pick_c     = pick_c ? bus.N1 : bus.N0;
        cyc_pick_c   = pick_c ? bus.CYC1 : bus.CYC0;
        ratio_pick_c = (n_pick_c < bitField'(NMIN)) ? bitField'(NMIN) : n_pick_c;
        ratio_m1_c   = ratio_r - bitField'(1);
        ratio_m2_c   = ratio_r - bitField'(2);
        req_win_c    = bus.REQ[win];
    end

    // Job FSM with registered outputs; all updates on the falling edge.
    always_ff @(negedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            state     <= IDLE;
            last      <= 1'b1;
            win       <= 1'b0;
            ratio_r   <= bitField'(NMIN);
            rem_r     <= '0;
            bus.GNT   <= 2'b00;
            bus.BUSY  <= 1'b0;
            bus.OUT   <= 1'b0;
            bus.Count <= '0;
            bus.DONE  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    bus.DONE  <= 2'b00;
                    bus.OUT   <= 1'b0;
                    bus.Count <= '0;
                    bus.GNT   <= 2'b00;
                    bus.BUSY  <= 1'b0;
                    if (bus.REQ != 2'b00) begin
                        win      <= pick_c;
                        ratio_r  <= ratio_pick_c;
                        rem_r    <= cyc_pick_c;
                        bus.GNT  <= {pick_c, ~pick_c};
                        bus.BUSY <= 1'b1;
                        state    <= (cyc_pick_c == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    if (!req_win_c) begin
                        // Requester withdrew: drop the job without DONE.
                        bus.GNT   <= 2'b00;
                        bus.BUSY  <= 1'b0;
                        bus.Count <= '0;
                        bus.OUT   <= 1'b0;
                        last      <= win;
                        state     <= IDLE;
                    end else if (bus.Count == ratio_m2_c) begin
                        bus.Count <= ratio_m1_c;
                        bus.OUT   <= 1'b1;
                    end else if (bus.Count == ratio_m1_c) begin
                        bus.Count <= '0;
                        bus.OUT   <= 1'b0;
                        rem_r     <= rem_r - bitField'(1);
                        if (rem_r == bitField'(1)) begin
                            state <= FIN;
                        end
                    end else begin
                        bus.Count <= bus.Count + bitField'(1);
                        bus.OUT   <= 1'b0;
                    end
                end
                FIN: begin
                    bus.DONE  <= {win, ~win};
                    bus.GNT   <= 2'b00;
                    bus.BUSY  <= 1'b0;
                    bus.Count <= '0;
                    bus.OUT   <= 1'b0;
                    last      <= win;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_scheduler.sv
// Directed bench for divider_scheduler with hand-computed expectations.
module tb_divider_scheduler;
    logic clk;
    logic clear;
    int   n_checks;
    int   n_errors;

    divider_scheduler_if #(.bitField(4)) bus ();

    divider_scheduler #(.bitField(4), .NMIN(2)) dut (
        .CLK   (clk),
        .CLEAR (clear),
        .bus   (bus)
    );

    // Free-running clock; falling edges at 5, 15, 25 ...
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n falling edges and sample 1ns later.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        #1;
        clear = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear    = 1'b1;
        bus.REQ  = 2'b00;
        bus.N0   = 4'd0;
        bus.N1   = 4'd0;
        bus.CYC0 = 4'd0;
        bus.CYC1 = 4'd0;

        // Reset state
        step(1);
        chk("rst_gnt",   32'(bus.GNT),   0);
        chk("rst_busy",  32'(bus.BUSY),  0);
        chk("rst_out",   32'(bus.OUT),   0);
        chk("rst_count", 32'(bus.Count), 0);
        chk("rst_done",  32'(bus.DONE),  0);
        clear = 1'b0;

        // Single job N0=10 CYC0=3, N0 changed mid-run must not matter
        bus.REQ = 2'b01; bus.N0 = 4'd10; bus.CYC0 = 4'd3;
        step(1);
        chk("job_gnt",  32'(bus.GNT),  2'b01);
        chk("job_busy", 32'(bus.BUSY), 1);
        chk("job_cnt0", 32'(bus.Count), 0);
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (k == 3) bus.N0 = 4'd5;
            if (k < 30) begin
                chk("job_count", 32'(bus.Count), 32'(k % 10));
                chk("job_out",   32'(bus.OUT),   32'((k % 10) == 9));
            end else begin
                chk("job_fin_count", 32'(bus.Count), 0);
                chk("job_fin_busy",  32'(bus.BUSY),  1);
                chk("job_fin_done",  32'(bus.DONE),  0);
            end
        end
        step(1);
        chk("job_done",      32'(bus.DONE), 2'b01);
        chk("job_done_gnt",  32'(bus.GNT),  2'b00);
        chk("job_done_busy", 32'(bus.BUSY), 0);
        bus.REQ = 2'b00;
        step(1);
        chk("job_done_clr", 32'(bus.DONE), 0);

        // Contention from reset: 0, then 1, then 0 again
        pulse_clear();
        bus.REQ = 2'b11; bus.N0 = 4'd3; bus.CYC0 = 4'd1; bus.N1 = 4'd2; bus.CYC1 = 4'd1;
        step(1);
        chk("rr_first", 32'(bus.GNT), 2'b01);
        step(2);
        chk("rr_out0", 32'(bus.OUT), 1);
        step(2);
        chk("rr_done0", 32'(bus.DONE), 2'b01);
        chk("rr_idle",  32'(bus.GNT),  2'b00);
        step(1);
        chk("rr_second", 32'(bus.GNT), 2'b10);
        step(1);
        chk("rr_out1", 32'(bus.OUT), 1);
        step(2);
        chk("rr_done1", 32'(bus.DONE), 2'b10);
        step(1);
        chk("rr_third", 32'(bus.GNT), 2'b01);
        bus.REQ = 2'b00;
        pulse_clear();

        // Ratios 0 and 1 clamp to 2: OUT every other edge
        for (int n = 0; n < 2; n++) begin
            bus.REQ = 2'b01; bus.N0 = 4'(n); bus.CYC0 = 4'd2;
            step(1);
            chk("clamp_gnt", 32'(bus.GNT), 2'b01);
            for (int k = 1; k <= 4; k++) begin
                step(1);
                chk("clamp_out", 32'(bus.OUT), 32'(k == 1 || k == 3));
            end
            step(1);
            chk("clamp_done", 32'(bus.DONE), 2'b01);
            bus.REQ = 2'b00;
            step(1);
        end

        // Zero periods: one grant cycle then DONE, no OUT
        bus.REQ = 2'b01; bus.N0 = 4'd4; bus.CYC0 = 4'd0;
        step(1);
        chk("cyc0_gnt", 32'(bus.GNT), 2'b01);
        chk("cyc0_out", 32'(bus.OUT), 0);
        step(1);
        chk("cyc0_done", 32'(bus.DONE), 2'b01);
        chk("cyc0_gnt_off", 32'(bus.GNT), 2'b00);
        chk("cyc0_out2", 32'(bus.OUT), 0);
        bus.REQ = 2'b00;
        step(1);

        // Maximum ratio 15, one period
        bus.REQ = 2'b01; bus.N0 = 4'd15; bus.CYC0 = 4'd1;
        step(1);
        for (int k = 1; k <= 15; k++) begin
            step(1);
            chk("max_count", 32'(bus.Count), (k == 15) ? 0 : 32'(k));
            chk("max_out",   32'(bus.OUT),   32'(k == 14));
        end
        step(1);
        chk("max_done", 32'(bus.DONE), 2'b01);
        bus.REQ = 2'b00;
        step(1);

        // Abort at Count=4, pending requester 1 granted after
        bus.REQ = 2'b01; bus.N0 = 4'd10; bus.CYC0 = 4'd2; bus.N1 = 4'd6; bus.CYC1 = 4'd2;
        step(1);
        step(4);
        chk("abort_cnt4", 32'(bus.Count), 4);
        bus.REQ = 2'b10;
        step(1);
        chk("abort_gnt",   32'(bus.GNT),   2'b00);
        chk("abort_count", 32'(bus.Count), 0);
        chk("abort_done",  32'(bus.DONE),  0);
        chk("abort_busy",  32'(bus.BUSY),  0);
        step(1);
        chk("abort_next", 32'(bus.GNT), 2'b10);
        step(1);
        chk("abort_next_cnt", 32'(bus.Count), 1);

        // Asynchronous clear between edges, then requester 0 has priority
        #2;
        clear = 1'b1;
        #1;
        chk("aclr_gnt",   32'(bus.GNT),   0);
        chk("aclr_busy",  32'(bus.BUSY),  0);
        chk("aclr_count", 32'(bus.Count), 0);
        chk("aclr_done",  32'(bus.DONE),  0);
        clear = 1'b0;
        bus.REQ = 2'b11; bus.N0 = 4'd2; bus.CYC0 = 4'd1;
        step(1);
        chk("aclr_prio", 32'(bus.GNT), 2'b01);
        bus.REQ = 2'b00;
        step(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
